// File: rtl/cipher_harness_pkg.sv
// Shared types for the cipher UUT harness: sequencer states and request modes.
package cipher_harness_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HOLD = 3'd1,
        RUN  = 3'd2,
        CAPT = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [1:0] MODE_ENC = 2'b00;
    localparam logic [1:0] MODE_DEC = 2'b01;
    localparam logic [1:0] MODE_RT  = 2'b10;

endpackage

// File: rtl/cipher_uut_harness_latency_counter.sv
// Run-length counter for the harness: reports the cycle number of the current
// RUN cycle (1-based) and flags when that number reaches the timeout limit.
module latency_counter #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] value,
    output logic             tc
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    // count_reg holds completed RUN cycles, so the current cycle is one more
    assign value = count_reg + CNT_W'(1);
    assign tc    = (value == CNT_W'(TIMEOUT));

endmodule

// File: rtl/cipher_uut_harness.sv
// Sequencer between the autotest controller and a block-cipher UUT: resets the
// UUT, runs it, captures result and latency, with timeout and round-trip mode.
module cipher_uut_harness
    import cipher_harness_pkg::*;
#(
    parameter int   BLOCK_W    = 64,
    parameter int   KEY_W      = 80,
    parameter int   CNT_W      = 16,
    parameter int   RST_CYCLES = 4,
    parameter int   TIMEOUT    = 4096,
    parameter logic ENC_LEVEL  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [1:0]         mode_i,
    input  logic [BLOCK_W-1:0] block_i,
    input  logic [KEY_W-1:0]   key_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [BLOCK_W-1:0] block_o,
    output logic [CNT_W-1:0]   cycles_o,
    output logic               roundtrip_ok_o,
    output logic               timeout_o,
    output logic               uut_rst_o,
    output logic [BLOCK_W-1:0] uut_block_o,
    output logic [KEY_W-1:0]   uut_key_o,
    output logic               uut_encdec_o,
    input  logic [BLOCK_W-1:0] uut_block_i,
    input  logic               uut_end_i
);

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

    state_t              state_reg;
    logic                phase_reg;
    logic [1:0]          mode_reg;
    logic [BLOCK_W-1:0]  plain_reg;
    logic [HOLD_W-1:0]   hold_cnt_reg;
    logic [1:0]          mode_norm;
    logic [CNT_W-1:0]    lat_value;
    logic                lat_tc;

    // the reserved mode behaves as plain encryption
    assign mode_norm = (mode_i == 2'b11) ? MODE_ENC : mode_i;

    latency_counter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_latency (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_reg == HOLD),
        .en    (state_reg == RUN),
        .value (lat_value),
        .tc    (lat_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            phase_reg      <= 1'b0;
            mode_reg       <= MODE_ENC;
            plain_reg      <= '0;
            hold_cnt_reg   <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            block_o        <= '0;
            cycles_o       <= '0;
            roundtrip_ok_o <= 1'b0;
            timeout_o      <= 1'b0;
            uut_rst_o      <= 1'b1;
            uut_block_o    <= '0;
            uut_key_o      <= '0;
            uut_encdec_o   <= ENC_LEVEL;
        end else begin
            done_o <= 1'b0;
            case (state_reg)
                IDLE: begin
                    uut_rst_o <= 1'b1;
                    if (start_i) begin
                        plain_reg      <= block_i;
                        mode_reg       <= mode_norm;
                        uut_block_o    <= block_i;
                        uut_key_o      <= key_i;
                        uut_encdec_o   <= (mode_norm == MODE_DEC) ? ~ENC_LEVEL : ENC_LEVEL;
                        timeout_o      <= 1'b0;
                        roundtrip_ok_o <= 1'b0;
                        busy_o         <= 1'b1;
                        phase_reg      <= 1'b0;
                        hold_cnt_reg   <= '0;
                        state_reg      <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt_reg == HOLD_LAST) begin
                        uut_rst_o <= 1'b0;
                        state_reg <= RUN;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
                    end
                end
                RUN: begin
                    // an end seen on the timeout cycle still counts as completion
                    if (uut_end_i && !uut_rst_o) begin
                        cycles_o  <= lat_value;
                        uut_rst_o <= 1'b1;
                        state_reg <= CAPT;
                    end else if (lat_tc) begin
                        timeout_o <= 1'b1;
                        block_o   <= '0;
                        cycles_o  <= CNT_W'(TIMEOUT);
                        uut_rst_o <= 1'b1;
                        busy_o    <= 1'b0;
                        done_o    <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                CAPT: begin
                    if (!phase_reg) begin
                        block_o <= uut_block_i;
                        if (mode_reg == MODE_RT) begin
                            uut_block_o  <= uut_block_i;
                            uut_encdec_o <= ~ENC_LEVEL;
                            phase_reg    <= 1'b1;
                            hold_cnt_reg <= '0;
                            state_reg    <= HOLD;
                        end else begin
                            busy_o    <= 1'b0;
                            done_o    <= 1'b1;
                            state_reg <= DONE;
                        end
                    end else begin
                        roundtrip_ok_o <= (uut_block_i == plain_reg);
                        busy_o         <= 1'b0;
                        done_o         <= 1'b1;
                        state_reg      <= DONE;
                    end
                end
                DONE: begin
                    uut_rst_o <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cipher_uut_harness.sv
// Scoreboard bench for cipher_uut_harness with an XOR-based stand-in cipher UUT.
module tb_cipher_uut_harness;

    localparam int BLOCK_W = 64;
    localparam int KEY_W   = 80;
    localparam int CNT_W   = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start_i = 1'b0;
    logic [1:0]         mode_i = 2'b00;
    logic [BLOCK_W-1:0] block_i = '0;
    logic [KEY_W-1:0]   key_i = '0;
    logic               busy_o, done_o, roundtrip_ok_o, timeout_o;
    logic [BLOCK_W-1:0] block_o;
    logic [CNT_W-1:0]   cycles_o;
    logic               uut_rst_o, uut_encdec_o, uut_end_i;
    logic [BLOCK_W-1:0] uut_block_o, uut_block_i;
    logic [KEY_W-1:0]   uut_key_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] blk;
        logic [15:0] cyc;
        logic        to;
        logic        rt;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    cipher_uut_harness dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .mode_i         (mode_i),
        .block_i        (block_i),
        .key_i          (key_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .block_o        (block_o),
        .cycles_o       (cycles_o),
        .roundtrip_ok_o (roundtrip_ok_o),
        .timeout_o      (timeout_o),
        .uut_rst_o      (uut_rst_o),
        .uut_block_o    (uut_block_o),
        .uut_key_o      (uut_key_o),
        .uut_encdec_o   (uut_encdec_o),
        .uut_block_i    (uut_block_i),
        .uut_end_i      (uut_end_i)
    );

    // stand-in UUT: XOR with the low key word, end raised on the 31st cycle out of reset
    logic [7:0] mcnt = '0;
    logic       model_hang = 1'b0;
    logic       model_corrupt = 1'b0;
    always @(posedge clk) begin
        if (uut_rst_o) mcnt <= '0;
        else if (mcnt < 8'd200) mcnt <= mcnt + 8'd1;
    end
    assign uut_end_i   = !uut_rst_o && (mcnt >= 8'd30) && !model_hang;
    assign uut_block_i = uut_block_o ^ uut_key_o[63:0]
                         ^ {63'b0, model_corrupt && (uut_encdec_o == 1'b0)};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // monitor: every done_o pulse pops one expected result
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst && done_o) begin
            if (done_prev) chk("done_one_cycle", 128'(done_prev), 128'(1'b0));
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 expected=0");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("block_o", 128'(block_o), 128'(e.blk));
                chk("cycles_o", 128'(cycles_o), 128'(e.cyc));
                chk("timeout_o", 128'(timeout_o), 128'(e.to));
                chk("roundtrip_ok_o", 128'(roundtrip_ok_o), 128'(e.rt));
                chk("busy_at_done", 128'(busy_o), 128'(1'b0));
                $display("txn done block=%h cycles=%0d timeout=%0b rt_ok=%0b",
                         block_o, cycles_o, timeout_o, roundtrip_ok_o);
            end
        end
        done_prev <= done_o;
    end

    task automatic push(input logic [63:0] b, input logic [15:0] c, input logic t, input logic r);
        exp_t e;
        e.blk = b; e.cyc = c; e.to = t; e.rt = r;
        sb_q.push_back(e);
    endtask

    // one-cycle start pulse; inputs are scrambled afterwards to prove they were latched
    task automatic issue(input logic [1:0] m, input logic [63:0] b, input logic [79:0] k);
        @(negedge clk);
        mode_i = m; block_i = b; key_i = k; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; block_i = ~b; key_i = ~k; mode_i = ~m;
    endtask

    // span counts the start cycle plus every busy cycle before the done cycle
    task automatic wait_done(input int limit, output int span);
        span = 1;
        while (!done_o && span < limit) begin
            span++;
            @(negedge clk);
        end
        if (!done_o) begin
            checks++;
            failures++;
            $display("FAIL wait_done actual=no_done expected=done_within_%0d", limit);
        end
    endtask

    localparam logic [79:0] KEY_A = 80'hABCD_00000000000000FF;
    localparam logic [79:0] KEY_B = 80'h1234_F0F0F0F0F0F0F0F0;

    initial begin
        int span;
        int guard;

        repeat (3) @(negedge clk);
        chk("rst_busy", 128'(busy_o), 128'(1'b0));
        chk("rst_done", 128'(done_o), 128'(1'b0));
        chk("rst_timeout", 128'(timeout_o), 128'(1'b0));
        chk("rst_rt_ok", 128'(roundtrip_ok_o), 128'(1'b0));
        chk("rst_block", 128'(block_o), 128'(0));
        chk("rst_cycles", 128'(cycles_o), 128'(0));
        chk("rst_uut_rst", 128'(uut_rst_o), 128'(1'b1));
        chk("rst_uut_block", 128'(uut_block_o), 128'(0));
        chk("rst_uut_key", 128'(uut_key_o), 128'(0));
        chk("rst_encdec", 128'(uut_encdec_o), 128'(1'b1));
        rst = 1'b0;

        // plain encrypt
        push(64'h0123456789ABCD10, 16'd31, 1'b0, 1'b0);
        issue(2'b00, 64'h0123456789ABCDEF, KEY_A);
        chk("busy_after_start", 128'(busy_o), 128'(1'b1));
        wait_done(200, span);
        chk("enc_span", 128'(span), 128'(37));

        // round trip
        push(64'h0123456789ABCD10, 16'd31, 1'b0, 1'b1);
        issue(2'b10, 64'h0123456789ABCDEF, KEY_A);
        wait_done(300, span);
        chk("rt_span", 128'(span), 128'(73));

        // round trip with a faulty decrypt
        model_corrupt = 1'b1;
        push(64'h0123456789ABCD10, 16'd31, 1'b0, 1'b0);
        issue(2'b10, 64'h0123456789ABCDEF, KEY_A);
        wait_done(300, span);
        model_corrupt = 1'b0;

        // decrypt direction
        push(64'h0123456789ABCDEF, 16'd31, 1'b0, 1'b0);
        issue(2'b01, 64'h0123456789ABCD10, KEY_A);
        chk("dec_encdec", 128'(uut_encdec_o), 128'(1'b0));
        wait_done(200, span);

        // reserved mode acts as encrypt
        push(64'hFFFFFFFFFFFFFFFF, 16'd31, 1'b0, 1'b0);
        issue(2'b11, 64'h0F0F0F0F0F0F0F0F, KEY_B);
        chk("mode11_encdec", 128'(uut_encdec_o), 128'(1'b1));
        wait_done(200, span);

        // UUT never finishes
        model_hang = 1'b1;
        push(64'h0, 16'd4096, 1'b1, 1'b0);
        issue(2'b00, 64'h0123456789ABCDEF, KEY_A);
        wait_done(5000, span);
        model_hang = 1'b0;

        // asynchronous reset in RUN cycle 10
        issue(2'b00, 64'h0123456789ABCDEF, KEY_A);
        guard = 0;
        while (uut_rst_o && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        chk("reached_run", 128'(uut_rst_o), 128'(1'b0));
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_uut_rst", 128'(uut_rst_o), 128'(1'b1));
        chk("arst_busy", 128'(busy_o), 128'(1'b0));
        chk("arst_timeout", 128'(timeout_o), 128'(1'b0));
        chk("arst_block", 128'(block_o), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        push(64'h0123456789ABCD10, 16'd31, 1'b0, 1'b0);
        issue(2'b00, 64'h0123456789ABCDEF, KEY_A);
        wait_done(200, span);

        // start while busy is ignored; start in the IDLE cycle after DONE is taken
        push(64'hFEDCBA98765432EF, 16'd31, 1'b0, 1'b0);
        issue(2'b00, 64'hFEDCBA9876543210, KEY_A);
        repeat (10) @(negedge clk);
        mode_i = 2'b01; block_i = 64'h5555555555555555; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_done(200, span);
        push(64'hFFFFFFFFFFFFFFFF, 16'd31, 1'b0, 1'b0);
        issue(2'b00, 64'h0F0F0F0F0F0F0F0F, KEY_B);
        wait_done(200, span);

        // start during DONE is ignored
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("done_start_ignored", 128'(busy_o), 128'(1'b0));
        repeat (50) @(negedge clk);
        chk("scoreboard_empty", 128'(sb_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
